// File: rtl/bp_pkg.sv
// Shared types and defaults for the branch resolution slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: pred_info_t slot record, default PC_STEP and CNT_W.
package bp_pkg;

  // Default fall-through increment for sequential fetch.
  localparam logic [31:0] PC_STEP = 32'd4;

  // Default width of the statistics counters.
  localparam int CNT_W = 32;

  // One pipeline slot: the fetched PC plus what the BTB said about it.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
  } pred_info_t;

endpackage

// File: rtl/branch_resolve_unit_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
// Latency: count reflects an increment one cycle after inc is sampled.
// Backpressure: none; inc is ignored once saturated.
// Ports: clk, rst (async, active-high), inc (increment request), count (current value).
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution: tracks BTB predictions through IF/ID and ID/EX, flags mispredicts, writes the BTB back.
// Latency: mispredict/redirect_pc combinational in EX; BTB update registered, visible one cycle after resolve.
// Backpressure: stall_id/stall_ex hold their slots; a resolving mispredict overrides stalls and flushes.
// Ports: clk, rst; IF-side PC + BTB prediction; stall_id/stall_ex/flush_id pipeline control;
//        EX outcome (ex_is_branch/ex_taken/ex_target); mispredict + redirect_pc; registered btb_* update;
//        branch_cnt / mispredict_cnt saturating statistics.
module branch_resolve_unit #(
  parameter int          CNT_W   = bp_pkg::CNT_W,
  parameter logic [31:0] PC_STEP = bp_pkg::PC_STEP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_pc,
  input  logic             if_btb_hit,
  input  logic             if_btb_br,
  input  logic [31:0]      if_pred_target,
  input  logic             stall_id,
  input  logic             stall_ex,
  input  logic             flush_id,
  input  logic             ex_is_branch,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic             btb_write,
  output logic             btb_br,
  output logic [31:0]      btb_pc_wr,
  output logic [31:0]      btb_pc_predict_wr,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  import bp_pkg::*;

  pred_info_t ifid_q, ifid_d;
  pred_info_t idex_q, idex_d;

  logic        res;
  logic [31:0] fallthru;
  logic        upd_vld;
  logic        upd_br;
  logic [31:0] upd_tgt;

  logic        btb_write_q;
  logic        btb_br_q, btb_br_d;
  logic [31:0] btb_pc_wr_q, btb_pc_wr_d;
  logic [31:0] btb_tgt_q, btb_tgt_d;

  // A slot resolves only when EX is valid and allowed to advance.
  assign res      = idex_q.valid & ~stall_ex;
  assign fallthru = idex_q.pc + PC_STEP;

  // Resolution: compare prediction with outcome, choose redirect and the BTB write data.
  always_comb begin
    mispredict  = 1'b0;
    redirect_pc = '0;
    upd_vld     = 1'b0;
    upd_br      = 1'b0;
    upd_tgt     = fallthru;
    if (res) begin
      if (ex_is_branch) begin
        upd_vld    = 1'b1;
        upd_br     = ex_taken;
        upd_tgt    = ex_taken ? ex_target : idex_q.pred_target;
        mispredict = (ex_taken != idex_q.pred_taken) |
                     (ex_taken & idex_q.pred_taken & (ex_target != idex_q.pred_target));
        if (mispredict) begin
          redirect_pc = ex_taken ? ex_target : fallthru;
        end
      end else if (idex_q.pred_taken) begin
        // BTB entry aliased onto a non-branch: undo the bogus redirect and demote the entry.
        mispredict  = 1'b1;
        redirect_pc = fallthru;
        upd_vld     = 1'b1;
        upd_br      = 1'b0;
        upd_tgt     = fallthru;
      end
    end
  end

  // Slot next-state: a mispredict outranks every stall and flush.
  always_comb begin
    ifid_d = ifid_q;
    if (flush_id || mispredict) begin
      ifid_d.valid = 1'b0;
    end else if (!stall_id) begin
      ifid_d.valid       = 1'b1;
      ifid_d.pc          = if_pc;
      ifid_d.pred_taken  = if_btb_hit & if_btb_br;
      ifid_d.pred_target = if_pred_target;
    end

    idex_d = idex_q;
    if (mispredict) begin
      idex_d.valid = 1'b0;
    end else if (!stall_ex) begin
      if (stall_id) begin
        idex_d.valid = 1'b0;  // ID held: push a bubble into EX
      end else begin
        idex_d = ifid_q;
      end
    end
  end

  // BTB data registers keep their last values when no update is issued.
  always_comb begin
    btb_br_d    = btb_br_q;
    btb_pc_wr_d = btb_pc_wr_q;
    btb_tgt_d   = btb_tgt_q;
    if (upd_vld) begin
      btb_br_d    = upd_br;
      btb_pc_wr_d = idex_q.pc;
      btb_tgt_d   = upd_tgt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_q      <= '0;
      idex_q      <= '0;
      btb_write_q <= 1'b0;
      btb_br_q    <= 1'b0;
      btb_pc_wr_q <= '0;
      btb_tgt_q   <= '0;
    end else begin
      ifid_q      <= ifid_d;
      idex_q      <= idex_d;
      btb_write_q <= upd_vld;
      btb_br_q    <= btb_br_d;
      btb_pc_wr_q <= btb_pc_wr_d;
      btb_tgt_q   <= btb_tgt_d;
    end
  end

  assign btb_write         = btb_write_q;
  assign btb_br            = btb_br_q;
  assign btb_pc_wr         = btb_pc_wr_q;
  assign btb_pc_predict_wr = btb_tgt_q;

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (res & ex_is_branch),
    .count (branch_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mispredict_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (res & mispredict),
    .count (mispredict_cnt)
  );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: stimulus pushes expectations, a monitor pops and compares.
// Latency: n/a. Backpressure: n/a.
// Counters built 4 bits wide so saturation is reached within the run.
module tb_branch_resolve_unit;

  localparam int CW  = 4;
  localparam int SAT = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   if_pc, if_pred_target, ex_target;
  logic          if_btb_hit, if_btb_br, stall_id, stall_ex, flush_id, ex_is_branch, ex_taken;
  logic          mispredict, btb_write, btb_br;
  logic [31:0]   redirect_pc, btb_pc_wr, btb_pc_predict_wr;
  logic [CW-1:0] branch_cnt, mispredict_cnt;

  always #5 clk = ~clk;

  branch_resolve_unit #(.CNT_W(CW), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst(rst),
    .if_pc(if_pc), .if_btb_hit(if_btb_hit), .if_btb_br(if_btb_br), .if_pred_target(if_pred_target),
    .stall_id(stall_id), .stall_ex(stall_ex), .flush_id(flush_id),
    .ex_is_branch(ex_is_branch), .ex_taken(ex_taken), .ex_target(ex_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .btb_write(btb_write), .btb_br(btb_br), .btb_pc_wr(btb_pc_wr), .btb_pc_predict_wr(btb_pc_predict_wr),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  typedef struct { bit v; bit [31:0] pc; bit pt; bit [31:0] tgt; } slot_t;
  typedef struct { int cyc; bit mp; bit [31:0] rd; int bc; int mc; } cexp_t;
  typedef struct { int cyc; bit br; bit [31:0] pc; bit [31:0] tgt; } uexp_t;

  cexp_t cq[$];
  uexp_t uq[$];
  slot_t m_id, m_ex;
  int    m_bc, m_mc;
  int    cyc;
  bit    mon_en;
  int    checks, failures;
  cexp_t c;
  uexp_t u;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endfunction

  task automatic model_reset();
    m_id = '{default: 0};
    m_ex = '{default: 0};
    m_bc = 0;
    m_mc = 0;
    cq.delete();
    uq.delete();
  endtask

  task automatic set_idle();
    if_pc = 0; if_btb_hit = 0; if_btb_br = 0; if_pred_target = 0;
    stall_id = 1; stall_ex = 1; flush_id = 0;
    ex_is_branch = 0; ex_taken = 0; ex_target = 0;
  endtask

  // One clock of stimulus; the reference model predicts this cycle's outputs and any BTB write.
  task automatic cycle(input bit [31:0] pc, input bit hit, input bit br, input bit [31:0] ptgt,
                       input bit sid, input bit sex, input bit fid,
                       input bit isb, input bit tk, input bit [31:0] xt);
    slot_t     nid, nex;
    bit        res, mp;
    bit [31:0] rd, ft;
    uexp_t     ue;
    @(negedge clk);
    if_pc = pc; if_btb_hit = hit; if_btb_br = br; if_pred_target = ptgt;
    stall_id = sid; stall_ex = sex; flush_id = fid;
    ex_is_branch = isb; ex_taken = tk; ex_target = xt;
    cyc++;
    res = m_ex.v && !sex;
    mp  = 0;
    rd  = 0;
    ft  = m_ex.pc + 32'd4;
    if (res && isb) begin
      if (tk != m_ex.pt) mp = 1;
      else if (tk && (xt != m_ex.tgt)) mp = 1;
      if (mp) rd = tk ? xt : ft;
      ue = '{cyc + 1, tk, m_ex.pc, tk ? xt : m_ex.tgt};
      uq.push_back(ue);
    end else if (res && m_ex.pt) begin
      mp = 1;
      rd = ft;
      ue = '{cyc + 1, 1'b0, m_ex.pc, ft};
      uq.push_back(ue);
    end
    cq.push_back('{cyc, mp, rd, m_bc, m_mc});
    if (res && isb && m_bc < SAT) m_bc++;
    if (res && mp && m_mc < SAT) m_mc++;
    nid = m_id;
    if (fid || mp) nid.v = 0;
    else if (!sid) nid = '{1'b1, pc, hit && br, ptgt};
    nex = m_ex;
    if (mp) nex.v = 0;
    else if (!sex) begin
      if (sid) nex.v = 0;
      else nex = m_id;
    end
    m_id = nid;
    m_ex = nex;
    mon_en = 1;
  endtask

  task automatic flush_cycle();
    cycle(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
  endtask

  // Empty both slots, then carry one instruction to EX and resolve it.
  task automatic branch_test(input bit [31:0] pc, input bit hit, input bit br, input bit [31:0] ptgt,
                             input bit isb, input bit tk, input bit [31:0] xt);
    flush_cycle();
    flush_cycle();
    cycle(pc, hit, br, ptgt, 0, 0, 0, 0, 0, 0);
    flush_cycle();
    cycle(0, 0, 0, 0, 0, 0, 1, isb, tk, xt);
  endtask

  // Monitor: compares every cycle's outputs and each BTB write against the queued expectations.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (mon_en) begin
        if (cq.size() == 0) begin
          chk("cycle_exp_present", 0, 1);
        end else begin
          c = cq.pop_front();
          chk("cycle_stamp", c.cyc, cyc);
          chk("mispredict", mispredict, c.mp);
          chk("redirect_pc", redirect_pc, c.rd);
          chk("branch_cnt", branch_cnt, c.bc);
          chk("mispredict_cnt", mispredict_cnt, c.mc);
        end
        if (btb_write) begin
          if (uq.size() == 0) begin
            chk("btb_write_spurious", 1, 0);
          end else begin
            u = uq.pop_front();
            chk("btb_write_cycle", cyc, u.cyc);
            chk("btb_br", btb_br, u.br);
            chk("btb_pc_wr", btb_pc_wr, u.pc);
            chk("btb_pc_predict_wr", btb_pc_predict_wr, u.tgt);
          end
        end else if (uq.size() != 0 && uq[0].cyc <= cyc) begin
          chk("btb_write_missing", 0, 1);
          void'(uq.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit [31:0] pcs [5];
    bit [31:0] tgts[4];
    checks = 0; failures = 0; cyc = 0; mon_en = 0;
    model_reset();
    set_idle();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_mispredict", mispredict, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_btb_write", btb_write, 0);
    chk("rst_btb_br", btb_br, 0);
    chk("rst_btb_pc_wr", btb_pc_wr, 0);
    chk("rst_btb_pc_predict_wr", btb_pc_predict_wr, 0);
    chk("rst_branch_cnt", branch_cnt, 0);
    chk("rst_mispredict_cnt", mispredict_cnt, 0);
    rst = 0;

    // Cold miss resolved taken.
    branch_test(32'h100, 0, 0, 0, 1, 1, 32'h200);
    #3;
    chk("cold_mispredict", mispredict, 1);
    chk("cold_redirect", redirect_pc, 32'h200);
    flush_cycle();
    #3;
    chk("cold_btb_write", btb_write, 1);
    chk("cold_btb_br", btb_br, 1);
    chk("cold_btb_pc_wr", btb_pc_wr, 32'h100);
    chk("cold_btb_tgt", btb_pc_predict_wr, 32'h200);
    chk("cold_branch_cnt", branch_cnt, 1);
    chk("cold_mispredict_cnt", mispredict_cnt, 1);

    // Correct prediction.
    branch_test(32'h100, 1, 1, 32'h200, 1, 1, 32'h200);
    #3;
    chk("hit_mispredict", mispredict, 0);
    flush_cycle();
    #3;
    chk("hit_btb_write", btb_write, 1);
    chk("hit_mispredict_cnt", mispredict_cnt, 1);

    // Wrong target, then predicted taken but fell through.
    branch_test(32'h100, 1, 1, 32'h200, 1, 1, 32'h240);
    #3;
    chk("wrongtgt_redirect", redirect_pc, 32'h240);
    flush_cycle();
    #3;
    chk("wrongtgt_btb_tgt", btb_pc_predict_wr, 32'h240);
    branch_test(32'h300, 1, 1, 32'h200, 1, 0, 0);
    #3;
    chk("nt_redirect", redirect_pc, 32'h304);
    flush_cycle();
    #3;
    chk("nt_btb_br", btb_br, 0);

    // Aliased non-branch at the top of the address space: fall-through wraps to 0.
    branch_test(32'hFFFF_FFFC, 1, 1, 32'h80, 0, 0, 0);
    #3;
    chk("alias_mispredict", mispredict, 1);
    chk("alias_redirect", redirect_pc, 0);
    flush_cycle();
    #3;
    chk("alias_btb_write", btb_write, 1);
    chk("alias_btb_br", btb_br, 0);
    chk("alias_btb_tgt", btb_pc_predict_wr, 0);

    // Mispredicting branch held in EX for three cycles, then released.
    flush_cycle();
    flush_cycle();
    cycle(32'h400, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    flush_cycle();
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 1, 1, 0, 1, 1, 32'h480);
      #3;
      chk("stallex_no_mispredict", mispredict, 0);
    end
    cycle(0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h480);
    #3;
    chk("stallex_release_mispredict", mispredict, 1);
    flush_cycle();
    flush_cycle();

    // Mispredict coinciding with stall_id clears both slots.
    cycle(32'h500, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(32'h504, 1, 1, 32'h600, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0, 1, 1, 32'h700);
    #3;
    chk("stallid_mispredict", mispredict, 1);
    cycle(0, 0, 0, 0, 1, 1, 0, 1, 1, 32'h999);
    #3;
    chk("stallid_ex_cleared", mispredict, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h999);
    cycle(0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h999);
    #3;
    chk("stallid_id_cleared", mispredict, 0);

    // Asynchronous reset with a mispredicting branch in EX.
    flush_cycle();
    flush_cycle();
    cycle(32'h500, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    flush_cycle();
    @(negedge clk);
    mon_en = 0;
    if_pc = 0; if_btb_hit = 0; if_btb_br = 0; if_pred_target = 0;
    stall_id = 0; stall_ex = 0; flush_id = 0;
    ex_is_branch = 1; ex_taken = 1; ex_target = 32'h600;
    #1;
    chk("prerst_mispredict", mispredict, 1);
    #1;
    rst = 1;
    #1;
    chk("midrst_mispredict", mispredict, 0);
    chk("midrst_redirect", redirect_pc, 0);
    chk("midrst_btb_write", btb_write, 0);
    chk("midrst_btb_br", btb_br, 0);
    chk("midrst_btb_pc_wr", btb_pc_wr, 0);
    chk("midrst_btb_tgt", btb_pc_predict_wr, 0);
    chk("midrst_branch_cnt", branch_cnt, 0);
    chk("midrst_mispredict_cnt", mispredict_cnt, 0);
    @(negedge clk);
    set_idle();
    #2;
    rst = 0;
    model_reset();
    @(negedge clk);
    #3;
    chk("postrst_btb_write", btb_write, 0);

    // Randomized traffic; counters saturate at 15 along the way.
    pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h300; pcs[3] = 32'hFFFF_FFFC; pcs[4] = 32'h200;
    tgts[0] = 32'h200; tgts[1] = 32'h240; tgts[2] = 32'h0; tgts[3] = 32'h1000;
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 3) == 0) ? ($urandom() & 32'hFFFF_FFFC) : pcs[$urandom_range(0, 4)],
            bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), tgts[$urandom_range(0, 3)],
            ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 1),
            ($urandom_range(0, 9) < 7), bit'($urandom_range(0, 1)), tgts[$urandom_range(0, 3)]);
    end

    flush_cycle();
    flush_cycle();
    flush_cycle();
    #4;
    chk("sat_branch_cnt", branch_cnt, m_bc);
    chk("update_queue_drained", uq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Branch resolution stage; it sits downstream of the branch target buffer and feeds it.
- Carries each fetched PC's BTB prediction (hit, taken, target) through internal IF/ID and ID/EX slots.
- Compares the prediction with the EX-stage outcome, raises mispredict flush and redirect, and produces the registered BTB update (write, br, pc_wr, pc_predict_wr).
- Keeps branch and mispredict statistics counters.

Parameters:
- CNT_W, 32, width of the statistics counters.
- PC_STEP, 4, fall-through increment for the redirect PC.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- if_pc  in  32  PC fetched this cycle
- if_btb_hit  in  1  BTB tag hit for if_pc
- if_btb_br  in  1  BTB predicts taken for if_pc
- if_pred_target  in  32  BTB predicted target for if_pc
- stall_id  in  1  hold the IF/ID slot
- stall_ex  in  1  hold the ID/EX slot
- flush_id  in  1  external squash of the IF/ID slot
- ex_is_branch  in  1  instruction in EX is a conditional branch or jump
- ex_taken  in  1  actual outcome
- ex_target  in  32  actual target
- mispredict  out  1  combinational; flush request for IF/ID/EX
- redirect_pc  out  32  combinational; correct next PC, valid when mispredict=1
- btb_write  out  1  registered BTB update strobe
- btb_br  out  1  registered taken bit for the BTB
- btb_pc_wr  out  32  registered PC being updated
- btb_pc_predict_wr  out  32  registered target being written
- branch_cnt  out  CNT_W  resolved branches
- mispredict_cnt  out  CNT_W  resolved mispredictions

Behaviour:
- Slots: each slot holds {valid, pc, pred_taken = btb_hit & btb_br, pred_target}.
- IF/ID slot, priority high to low:
  - flush_id or mispredict: valid <= 0.
  - stall_id: hold.
  - otherwise: load the IF inputs with valid = 1.
- ID/EX slot, priority high to low:
  - mispredict: valid <= 0.
  - stall_ex: hold.
  - stall_id (bubble): valid <= 0.
  - otherwise: take the IF/ID slot.
- Resolve condition: res = ex_slot.valid & ~stall_ex. No action when res = 0.
- Mispredict (combinational, asserted only when res = 1):
  - Branch, ex_is_branch = 1: mispredict = (ex_taken != pred_taken) | (ex_taken & pred_taken & (ex_target != pred_target)).
  - Branch redirect_pc = ex_taken ? ex_target : pc + PC_STEP.
  - Non-branch, ex_is_branch = 0 with pred_taken = 1 (aliased entry): mispredict = 1, redirect_pc = pc + PC_STEP.
  - redirect_pc = 0 whenever mispredict = 0.
- BTB update, registered and visible the cycle after res:
  - Branch: btb_write = 1, btb_br = ex_taken, btb_pc_wr = pc, btb_pc_predict_wr = ex_taken ? ex_target : pred_target.
  - Aliased non-branch: btb_write = 1, btb_br = 0, btb_pc_predict_wr = pc + PC_STEP.
  - Otherwise: btb_write = 0; the data outputs hold their last values.
- Counters:
  - branch_cnt += 1 on res & ex_is_branch.
  - mispredict_cnt += 1 on res & mispredict.
  - Both saturate at all-ones; no wrap.
- Arithmetic: pc + PC_STEP is 32-bit modulo, so 0xFFFFFFFC + 4 = 0.
- Simultaneous events: a mispredict in EX outranks stall_id and flush_id. Both slots are cleared at the same edge as the BTB update registers load.
- Reset: asynchronous, and may assert mid-operation.
  - Clears slot valid bits, all btb_* outputs and both counters to 0.
  - mispredict = 0 and redirect_pc = 0 while the slots are invalid.
  - No update is issued for an instruction in flight at reset.

Decomposition:
- Shared package bp_pkg:
  - typedef pred_info_t {valid, pc[31:0], pred_taken, pred_target[31:0]}.
  - Constants PC_STEP and CNT_W.
- One sub-module, sat_counter (parameter W; inc in; saturating count out), instantiated twice.

Test Plan:
- Cold miss: if_pc = 0x100, if_btb_hit = 0, EX resolves taken to 0x200 → mispredict = 1, redirect_pc = 0x200. Next cycle btb_write = 1, btb_br = 1, btb_pc_wr = 0x100, btb_pc_predict_wr = 0x200. branch_cnt = 1, mispredict_cnt = 1.
- Correct prediction: hit = 1, br = 1, pred_target = 0x200, actual taken to 0x200 → mispredict = 0; btb_write = 1, btb_br = 1; mispredict_cnt unchanged.
- Wrong target: predicted 0x200, actual 0x240 → redirect_pc = 0x240, btb_pc_predict_wr = 0x240. Predicted taken, actual not-taken at pc = 0x300 → redirect_pc = 0x304, btb_br = 0.
- Stall/flush: stall_ex = 1 for 3 cycles while a mispredicting branch sits in EX → no mispredict until release, exactly one update. A mispredict in the same cycle as stall_id = 1 → both slots invalid next cycle.
- Aliasing and saturation:
  - ex_is_branch = 0 with pred_taken = 1 at pc = 0xFFFFFFFC → redirect_pc = 0x0, btb_br = 0.
  - With CNT_W = 4, resolve 20 branches → branch_cnt stops at 15.
- Reset mid-operation: assert rst asynchronously with a branch in EX → outputs 0 immediately; no btb_write after release.
